// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with valid/ready handshake and flush
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic              r_sa, r_sb;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic [2*XLEN-1:0] r_prod;
  logic [CW-1:0]     r_cnt;

  logic              w_signed, w_sa, w_sb, w_is_div, w_b_zero, w_ovf, w_special, w_accept;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec_res, w_q, w_r, w_fix;
  logic [2*XLEN-1:0] w_step, w_prod_fix;
  logic [XLEN:0]     w_tr, w_diff, w_add;

  assign in_ready  = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign result    = r_result;

  assign w_signed   = op == 3'd0 || op == 3'd1 || op == 3'd3 || op == 3'd5;
  assign w_sa       = w_signed & a[XLEN-1];
  assign w_sb       = w_signed & b[XLEN-1];
  assign w_abs_a    = w_sa ? -a : a;
  assign w_abs_b    = w_sb ? -b : b;
  assign w_is_div   = op >= 3'd3 && op != 3'd7;
  assign w_b_zero   = b == '0;
  assign w_ovf      = (op == 3'd3 || op == 3'd5) && a == MIN_INT && b == '1;
  assign w_special  = op == 3'd7 || (w_is_div && (w_b_zero || w_ovf));
  assign w_spec_res = op == 3'd7 ? '0 :
                      w_b_zero   ? ((op == 3'd3 || op == 3'd4) ? '1 : a) :
                      op == 3'd3 ? MIN_INT : '0;
  assign w_accept   = in_valid & in_ready & ~flush;

  // r_prod holds {remainder, quotient} for divides and {acc, multiplier} for multiplies
  always_comb begin
    w_step = r_prod;
    w_tr   = '0;
    w_diff = '0;
    w_add  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_op >= 3'd3) begin
        w_tr   = w_step[2*XLEN-1:XLEN-1];
        w_diff = w_tr - {1'b0, r_b};
        w_step = {w_diff[XLEN] ? w_tr[XLEN-1:0] : w_diff[XLEN-1:0], w_step[XLEN-2:0], ~w_diff[XLEN]};
      end else begin
        w_add  = {1'b0, w_step[2*XLEN-1:XLEN]} + (w_step[0] ? {1'b0, r_a} : '0);
        w_step = {w_add, w_step[XLEN-1:1]};
      end
    end
  end

  assign w_prod_fix = (r_sa ^ r_sb) ? -r_prod : r_prod;
  assign w_q        = r_prod[XLEN-1:0];
  assign w_r        = r_prod[2*XLEN-1:XLEN];
  assign w_fix      = r_op == 3'd0                 ? w_prod_fix[XLEN-1:0] :
                      r_op <= 3'd2                 ? w_prod_fix[2*XLEN-1:XLEN] :
                      (r_op == 3'd3 || r_op == 3'd4) ? ((r_sa ^ r_sb) ? -w_q : w_q) :
                      r_sa ? -w_r : w_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      if (w_accept) begin
        r_op    <= op;
        r_sa    <= w_sa;
        r_sb    <= w_sb;
        r_a     <= w_abs_a;
        r_b     <= w_abs_b;
        r_prod  <= {{XLEN{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
        r_cnt   <= CW'(N);
        r_state <= w_special ? DONE : CALC;
        if (w_special) r_result <= w_spec_res;
      end
      if (r_state == CALC) begin
        r_prod <= w_step;
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_state <= FIX;
      end
      if (r_state == FIX) begin
        r_result <= w_fix;
        r_state  <= DONE;
      end
      if (r_state == DONE && out_ready) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and model-checked sweep over three muldiv_unit configurations
module tb_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  int          sel = 0, n_tot = 0, n_pass = 0;
  logic [2:0]  ir, ov, bz;
  logic [31:0] r0, r2;
  logic [15:0] r1;
  logic        m_ir, m_ov, m_bz;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 0), .in_ready(ir[0]), .op(op), .a(a), .b(b), .out_valid(ov[0]),
    .out_ready(out_ready && sel == 0), .result(r0), .busy(bz[0]));
  muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(4)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 1), .in_ready(ir[1]), .op(op), .a(a[15:0]), .b(b[15:0]), .out_valid(ov[1]),
    .out_ready(out_ready && sel == 1), .result(r1), .busy(bz[1]));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid && sel == 2), .in_ready(ir[2]), .op(op), .a(a), .b(b), .out_valid(ov[2]),
    .out_ready(out_ready && sel == 2), .result(r2), .busy(bz[2]));

  assign m_ir  = ir[sel];
  assign m_ov  = ov[sel];
  assign m_bz  = bz[sel];
  assign m_res = sel == 1 ? {16'h0, r1} : sel == 2 ? r2 : r0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int w);
    logic [31:0] m;
    longint sx, sy, mn, r;
    longint unsigned ux, uy;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    ux = {32'h0, x & m};
    uy = {32'h0, y & m};
    sx = (w == 32) ? longint'($signed(x)) : longint'($signed(x[15:0]));
    sy = (w == 32) ? longint'($signed(y)) : longint'($signed(y[15:0]));
    mn = -(longint'(1) <<< (w - 1));
    case (o)
      3'd0: r = sx * sy;
      3'd1: r = (sx * sy) >>> w;
      3'd2: r = longint'((ux * uy) >> w);
      3'd3: r = (sy == 0) ? -1 : (sx == mn && sy == -1) ? mn : sx / sy;
      3'd4: r = (uy == 0) ? -1 : longint'(ux / uy);
      3'd5: r = (sy == 0) ? sx : (sx == mn && sy == -1) ? 0 : sx % sy;
      3'd6: r = (uy == 0) ? longint'(ux) : longint'(ux % uy);
      default: r = 0;
    endcase
    return r[31:0] & m;
  endfunction

  task automatic start(input int s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit drop);
    int k;
    sel = s; op = o; a = x; b = y; in_valid = 1'b1; k = 0;
    while (!m_ir && k < 100) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    if (drop) in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int lat);
    lat = 1;
    while (!m_ov && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic run(input string tag, input int s, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp, input int lat_exp, input bit drop);
    int lat;
    start(s, o, x, y, drop);
    wait_ov(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    chk(tag, m_res, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_take"}, 32'({m_ov, m_ir}), 32'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, w, nn;
    bit ok, spec;
    logic [2:0]  o;
    logic [31:0] x, y, msk, mn;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'({m_ir, m_ov, m_bz}), 32'b100);
    chk("rst_result", m_res, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("mul",   0, 3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    run("mulh",  0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1);
    run("mulhu", 0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);
    run("mulmin",0, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b1);
    run("div",   0, 3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 1'b1);
    run("mod",   0, 3'd5, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 1'b1);
    run("divu",  0, 3'd4, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 34, 1'b1);
    run("modu",  0, 3'd6, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 34, 1'b1);
    run("div0",  0, 3'd3, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 1'b1);
    run("mod0",  0, 3'd5, 32'd5,        32'd0,        32'd5,        1, 1'b1);
    run("divov", 0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    run("modov", 0, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1, 1'b1);
    run("op7",   0, 3'd7, 32'd9,        32'd3,        32'h0,        1, 1'b1);

    start(0, 3'd0, 32'd3, 32'd5, 1'b1);
    wait_ov(lat);
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!(m_ov && !m_ir && m_res == 32'd15)) ok = 1'b0;
    end
    chk("hold", 32'(ok), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_idle", 32'({m_ir, m_ov}), 32'b10);

    start(0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'({m_ir, m_ov, m_bz}), 32'b100);
    chk("arst_result", m_res, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    op = 3'd4; a = 32'd100; b = 32'd7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_noacc", 32'(m_bz), 32'd0);

    start(0, 3'd0, 32'd7, 32'd3, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", 32'({m_bz, m_ir}), 32'b01);
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_ov) ok = 1'b0;
    end
    chk("flush_noval", 32'(ok), 32'd1);
    run("divu_after", 0, 3'd4, 32'd100, 32'd7, 32'd14, 34, 1'b1);

    start(0, 3'd7, 32'd0, 32'd0, 1'b1);
    chk("done_valid", 32'(m_ov), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done", 32'({m_ov, m_ir}), 32'b01);

    for (int s = 0; s < 3; s++) begin
      w   = (s == 1) ? 16 : 32;
      nn  = (s == 0) ? 34 : (s == 1) ? 6 : 18;
      msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      mn  = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
      for (int i = 0; i < 30; i++) begin
        o = 3'($urandom_range(0, 7));
        x = $urandom & msk;
        y = $urandom & msk;
        case ($urandom_range(0, 5))
          0: y = 32'd0;
          1: y = 32'($urandom_range(1, 15));
          2: begin x = mn; y = msk; end
          default: ;
        endcase
        spec = o == 3'd7 || (o >= 3'd3 && (y == 32'd0 || ((o == 3'd3 || o == 3'd5) && x == mn && y == msk)));
        run("rnd", s, o, x, y, ref_model(o, x, y, w), spec ? 1 : nn, 1'b0);
      end
      in_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
